// File: rtl/demo_slave_responder.sv
// -----------------------------------------------------------------------------
// demo_slave_responder
//   Simple bus slave that answers one request at a time. A request is captured
//   in IDLE, optionally delayed by WAIT_CYCLES wait states, then serviced
//   against a small local register array and answered with a one-cycle
//   response strobe.
//
// Ports
//   clk          rising-edge clock
//   rstn         synchronous active-low reset
//   req_valid    single-cycle request strobe (only honoured while s_ready=1)
//   req_addr     request address
//   req_wdata    write data
//   req_rw_mode  0 = read, 1 = write
//   s_ready      high while the responder can accept a request (IDLE only)
//   rsp_valid    single-cycle completion strobe
//   rsp_rdata    read data / write echo / all-ones on miss (held until next access)
//   rsp_err      address-miss flag (held until next access)
//   led          last data byte successfully written
//   txn_count    completed-transaction counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module demo_slave_responder #(
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    MEM_ADDR_WIDTH = 5,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 16'h4000,
  parameter int                    WAIT_CYCLES    = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_rw_mode,
  output logic                  s_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] led,
  output logic [7:0]            txn_count
);

  localparam int MEM_DEPTH = 2 ** MEM_ADDR_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - MEM_ADDR_WIDTH;
  localparam logic [TAG_WIDTH-1:0] BASE_TAG = BASE_ADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
  // Last value of the wait counter before leaving WAIT; unused when WAIT_CYCLES=0.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESPOND
  } state_t;

  state_t                      state;
  logic [3:0]                  wait_cnt;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [DATA_WIDTH-1:0]       wdata_q;
  logic                        rw_q;
  logic [DATA_WIDTH-1:0]       mem [MEM_DEPTH];

  logic                        hit;
  logic [MEM_ADDR_WIDTH-1:0]   idx;

  assign hit = (addr_q[ADDR_WIDTH-1:MEM_ADDR_WIDTH] == BASE_TAG);
  assign idx = addr_q[MEM_ADDR_WIDTH-1:0];

  // NOTE: all state here is sequential, so every assignment uses <= ; mixing in
  // blocking assignments would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      s_ready   <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      led       <= '0;
      txn_count <= '0;
      wait_cnt  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      // NOTE: the register array must read back as zero after reset, so it is
      // cleared here; this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rw_q     <= req_rw_mode;
            wait_cnt <= '0;
            s_ready  <= 1'b0;
            state    <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
          end
        end

        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= S_ACCESS;
          else                       wait_cnt <= wait_cnt + 4'd1;
        end

        S_ACCESS: begin
          rsp_err <= !hit;
          if (!hit) begin
            rsp_rdata <= '1;
          end else if (rw_q) begin
            mem[idx]  <= wdata_q;
            led       <= wdata_q;
            rsp_rdata <= wdata_q;
          end else begin
            rsp_rdata <= mem[idx];
          end
          // Registered outputs: raise the strobe and bump the counter on entry
          // to RESPOND so both are visible during the response cycle.
          rsp_valid <= 1'b1;
          txn_count <= txn_count + 8'd1;
          state     <= S_RESPOND;
        end

        S_RESPOND: begin
          rsp_valid <= 1'b0;
          s_ready   <= 1'b1;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demo_slave_responder.sv
// -----------------------------------------------------------------------------
// tb_demo_slave_responder
//   Two responder instances: inst 0 with WAIT_CYCLES=2, inst 1 with
//   WAIT_CYCLES=0. Stimulus pushes hand-computed expected responses into a
//   per-instance queue; independent monitors pop and compare whenever
//   rsp_valid is seen.
// -----------------------------------------------------------------------------
module tb_demo_slave_responder;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic [7:0] led;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        req_valid   [2];
  logic [15:0] req_addr    [2];
  logic [7:0]  req_wdata   [2];
  logic        req_rw_mode [2];
  logic        s_ready     [2];
  logic        rsp_valid   [2];
  logic [7:0]  rsp_rdata   [2];
  logic        rsp_err     [2];
  logic [7:0]  led         [2];
  logic [7:0]  txn_count   [2];

  int   cyc;
  int   n_pass;
  int   n_total;
  exp_t q0[$];
  exp_t q1[$];

  demo_slave_responder #(.WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_rw_mode(req_rw_mode[0]),
    .s_ready(s_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .led(led[0]), .txn_count(txn_count[0])
  );

  demo_slave_responder #(.WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_rw_mode(req_rw_mode[1]),
    .s_ready(s_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .led(led[1]), .txn_count(txn_count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int q_size(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void push_exp(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic exp_t pop_exp(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Called at a negedge. Waits (bounded) for s_ready, drives a one-cycle
  // request, and optionally queues the expected response.
  task automatic issue(input int k, input logic [15:0] addr, input logic [7:0] wd,
                       input logic rw, input logic push,
                       input logic [7:0] erd, input logic eerr,
                       input logic [7:0] eled, input logic [7:0] ecnt);
    exp_t e;
    int   n;
    n = 0;
    while (!s_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready[k]) check($sformatf("i%0d_ready_timeout", k), 32'(s_ready[k]), 1);
    req_addr[k]    = addr;
    req_wdata[k]   = wd;
    req_rw_mode[k] = rw;
    req_valid[k]   = 1'b1;
    e.rdata = erd;
    e.err   = eerr;
    e.led   = eled;
    e.cnt   = ecnt;
    e.cyc   = cyc + wait_of(k) + 2;
    if (push) push_exp(k, e);
    @(negedge clk);
    req_valid[k] = 1'b0;
  endtask

  task automatic monitor(input int k);
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid[k]) begin
        if (q_size(k) == 0) begin
          check($sformatf("i%0d_unexpected_rsp", k), 32'(rsp_valid[k]), 0);
        end else begin
          e = pop_exp(k);
          check($sformatf("i%0d_rdata", k),     32'(rsp_rdata[k]), 32'(e.rdata));
          check($sformatf("i%0d_err", k),       32'(rsp_err[k]),   32'(e.err));
          check($sformatf("i%0d_led", k),       32'(led[k]),       32'(e.led));
          check($sformatf("i%0d_txn_count", k), 32'(txn_count[k]), 32'(e.cnt));
          check($sformatf("i%0d_latency", k),   32'(cyc),          32'(e.cyc));
          check($sformatf("i%0d_busy_at_rsp", k), 32'(s_ready[k]), 0);
          @(negedge clk);
          check($sformatf("i%0d_valid_drop", k), 32'(rsp_valid[k]), 0);
          check($sformatf("i%0d_ready_back", k), 32'(s_ready[k]),   1);
          check($sformatf("i%0d_rdata_hold", k), 32'(rsp_rdata[k]), 32'(e.rdata));
          check($sformatf("i%0d_err_hold", k),   32'(rsp_err[k]),   32'(e.err));
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    int n;
    n_pass  = 0;
    n_total = 0;
    rstn    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k]   = 1'b0;
      req_addr[k]    = '0;
      req_wdata[k]   = '0;
      req_rw_mode[k] = 1'b0;
    end
    repeat (3) @(negedge clk);

    // Reset state of both instances.
    for (int k = 0; k < 2; k++) begin
      check($sformatf("i%0d_rst_s_ready", k),   32'(s_ready[k]),   1);
      check($sformatf("i%0d_rst_rsp_valid", k), 32'(rsp_valid[k]), 0);
      check($sformatf("i%0d_rst_rsp_err", k),   32'(rsp_err[k]),   0);
      check($sformatf("i%0d_rst_rsp_rdata", k), 32'(rsp_rdata[k]), 0);
      check($sformatf("i%0d_rst_led", k),       32'(led[k]),       0);
      check($sformatf("i%0d_rst_txn_count", k), 32'(txn_count[k]), 0);
    end
    rstn = 1'b1;
    @(negedge clk);

    // Instance 0 (WAIT_CYCLES=2): hits, misses, index boundaries.
    //       addr      wdata rw push  rdata  err  led   cnt
    issue(0, 16'h4001, 8'hA5, 1, 1,   8'hA5, 0, 8'hA5, 8'd1);
    issue(0, 16'h4001, 8'h00, 0, 1,   8'hA5, 0, 8'hA5, 8'd2);
    issue(0, 16'h4002, 8'h00, 0, 1,   8'h00, 0, 8'hA5, 8'd3);
    issue(0, 16'h8001, 8'h3C, 1, 1,   8'hFF, 1, 8'hA5, 8'd4);
    issue(0, 16'h4001, 8'h00, 0, 1,   8'hA5, 0, 8'hA5, 8'd5);
    issue(0, 16'h401F, 8'h5A, 1, 1,   8'h5A, 0, 8'h5A, 8'd6);
    issue(0, 16'h4020, 8'h00, 0, 1,   8'hFF, 1, 8'h5A, 8'd7);
    issue(0, 16'h401F, 8'h00, 0, 1,   8'h5A, 0, 8'h5A, 8'd8);

    // Second request while busy must be dropped entirely.
    issue(0, 16'h4002, 8'h77, 1, 1,   8'h77, 0, 8'h77, 8'd9);
    req_addr[0] = 16'h4003; req_wdata[0] = 8'h11; req_rw_mode[0] = 1'b1;
    req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    issue(0, 16'h4003, 8'h00, 0, 1,   8'h00, 0, 8'h77, 8'd10);

    // Reset during WAIT of a write; a request held during reset is ignored.
    issue(0, 16'h4003, 8'h99, 1, 0,   8'h00, 0, 8'h00, 8'd0);
    rstn = 1'b0;
    req_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    req_valid[0] = 1'b0;
    check("i0_abort_txn_count", 32'(txn_count[0]), 0);
    check("i0_abort_led",       32'(led[0]),       0);
    check("i0_abort_s_ready",   32'(s_ready[0]),   1);
    rstn = 1'b1;
    @(negedge clk);
    issue(0, 16'h4003, 8'h00, 0, 1,   8'h00, 0, 8'h00, 8'd1);
    issue(0, 16'h4001, 8'h00, 0, 1,   8'h00, 0, 8'h00, 8'd2);

    // Instance 1 (WAIT_CYCLES=0): 256 back-to-back reads, counter wraps.
    for (int i = 0; i < 256; i++) begin
      issue(1, 16'h4000, 8'h00, 0, 1, 8'h00, 0, 8'h00, 8'((i + 1) % 256));
    end

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", 32'(q0.size() + q1.size()), 0);
    repeat (5) @(negedge clk);
    check("i1_wrap_txn_count", 32'(txn_count[1]), 0);
    check("i0_final_txn_count", 32'(txn_count[0]), 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/demo_slave_responder.md
DEMO_SLAVE_RESPONDER -- requirements
Module: demo_slave_responder

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 16, bus address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 8, bus data width.
REQ-003 The module SHALL have parameter MEM_ADDR_WIDTH, default 5, local register-array index width (2^MEM_ADDR_WIDTH entries).
REQ-004 The module SHALL have parameter BASE_ADDR, default 16'h4000, device base address.
REQ-005 The module SHALL have parameter WAIT_CYCLES, default 2, range 0..15, inserted wait states per transaction.
REQ-006 clk  in  1  clock; all logic on its rising edge.
REQ-007 rstn  in  1  reset, synchronous, active-low.
REQ-008 req_valid  in  1  single-cycle request strobe from the bus slave port.
REQ-009 req_addr  in  ADDR_WIDTH  request address.
REQ-010 req_wdata  in  DATA_WIDTH  write data.
REQ-011 req_rw_mode  in  1  0 = read, 1 = write.
REQ-012 s_ready  out  1  high when the responder can accept a request.
REQ-013 rsp_valid  out  1  single-cycle completion strobe.
REQ-014 rsp_rdata  out  DATA_WIDTH  read data, valid when rsp_valid is high.
REQ-015 rsp_err  out  1  address-miss flag, valid when rsp_valid is high.
REQ-016 led  out  DATA_WIDTH  last successfully written data byte.
REQ-017 txn_count  out  8  completed-transaction counter.

Function
REQ-018 FSM states: IDLE, WAIT, ACCESS, RESPOND; s_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE with req_valid=1, the module SHALL capture req_addr, req_wdata and req_rw_mode into internal registers and enter WAIT, or ACCESS directly when WAIT_CYCLES=0.
REQ-020 A req_valid pulse outside IDLE SHALL be ignored, with no capture, no queueing and no error.
REQ-021 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit counter cleared on entry, then go to ACCESS.
REQ-022 Hit SHALL be defined as captured addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH] == BASE_ADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH]; the index SHALL be addr[MEM_ADDR_WIDTH-1:0].
REQ-023 ACCESS SHALL last one cycle, as follows:
- write hit: array[index] <= wdata and led <= wdata;
- read hit: rsp_rdata <= array[index];
- any miss: no array or led change; rsp_rdata <= all-ones; error latched.
REQ-024 On a write, rsp_rdata SHALL be loaded with the written data (echo).
REQ-025 RESPOND SHALL last one cycle:
- rsp_valid=1 and rsp_err=miss;
- txn_count SHALL increment, errors included, wrapping 255 -> 0;
- next state SHALL be IDLE.
REQ-026 Latency: req_valid accepted at cycle T SHALL produce rsp_valid at T+WAIT_CYCLES+2; s_ready SHALL be low from T+1 through T+WAIT_CYCLES+2 and high again at T+WAIT_CYCLES+3.
REQ-027 rsp_rdata and rsp_err SHALL hold their values after RESPOND until the next ACCESS; rsp_valid SHALL be 0 outside RESPOND.
REQ-028 A read of an index in ACCESS SHALL return the data of any write completed in an earlier transaction, with no stale-data hazard.
REQ-029 Back-to-back operation: a req_valid in the first IDLE cycle after RESPOND SHALL be accepted.

Reset
REQ-030 While rstn=0 at a clock edge:
- state SHALL go to IDLE;
- s_ready=1;
- rsp_valid=0, rsp_err=0, rsp_rdata=0;
- led=0, txn_count=0;
- wait counter=0;
- all array entries SHALL be 0.
REQ-031 Reset mid-transaction (WAIT, ACCESS or RESPOND) SHALL abort it, with no rsp_valid pulse, no txn_count increment, and array/led cleared.
REQ-032 req_valid coincident with rstn=0 SHALL be ignored.

Verification
REQ-033 Write 0x4001, data 0xA5, WAIT_CYCLES=2, req at T -> rsp_valid at T+4, rsp_err=0, rsp_rdata=0xA5, led=0xA5, txn_count=1, s_ready high at T+5.
REQ-034 Read 0x4001 after REQ-033 -> rsp_rdata=0xA5, rsp_err=0; a read of 0x4002 -> 0x00.
REQ-035 Write 0x8001, data 0x3C -> rsp_err=1, rsp_rdata=0xFF, led unchanged, read of 0x4001 still 0xA5, txn_count incremented.
REQ-036 Second req_valid at T+2 during an active transaction -> ignored, exactly one rsp_valid, txn_count +1 only.
REQ-037 rstn low during WAIT of a write to 0x4003 -> no rsp_valid, txn_count=0, later read of 0x4003 = 0x00.
REQ-038 Run 256 back-to-back reads, each issued on the first s_ready cycle -> txn_count wraps to 0; with WAIT_CYCLES=0, rsp_valid at T+2.
